// File: rtl/sap_control_sequencer_pkg.sv
//------------------------------------------------------------------------------
// sap_control_sequencer_pkg : shared opcodes, T-state and control-word indices
// rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sap_control_sequencer_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int T_WIDTH = 6;
  localparam int T1 = 0;
  localparam int T2 = 1;
  localparam int T3 = 2;
  localparam int T4 = 3;
  localparam int T5 = 4;
  localparam int T6 = 5;

  localparam logic [T_WIDTH-1:0] T_RESET = 6'b000001;

  // Control-word bit positions, shared with the datapath top.
  localparam int CW_PC_INC  = 0;
  localparam int CW_PC_OUT  = 1;
  localparam int CW_MAR_IN  = 2;
  localparam int CW_RAM_OUT = 3;
  localparam int CW_IR_IN   = 4;
  localparam int CW_IR_OUT  = 5;
  localparam int CW_ACC_IN  = 6;
  localparam int CW_ACC_OUT = 7;
  localparam int CW_B_IN    = 8;
  localparam int CW_SUB     = 9;
  localparam int CW_ALU_OUT = 10;
  localparam int CW_OUT_IN  = 11;
  localparam int CW_WIDTH   = 12;

  typedef logic [CW_WIDTH-1:0] ctrl_word_t;

  function automatic logic ring_is_onehot(input logic [T_WIDTH-1:0] v);
    return (v != '0) && ((v & (v - 6'd1)) == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sap_control_sequencer_if.sv
//------------------------------------------------------------------------------
// sap_control_sequencer_if : opcode in, control word / ring state out
// rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sap_control_sequencer_if;

  logic [3:0] opcode;
  logic       pc_inc;
  logic       pc_out;
  logic       mar_in;
  logic       ram_out;
  logic       ir_in;
  logic       ir_out;
  logic       acc_in;
  logic       acc_out;
  logic       b_in;
  logic       sub;
  logic       alu_out;
  logic       out_in;
  logic [5:0] t_state;
  logic       halted;

  modport master (
    input  opcode,
    output pc_inc, pc_out, mar_in, ram_out, ir_in, ir_out,
           acc_in, acc_out, b_in, sub, alu_out, out_in,
           t_state, halted
  );

  modport slave (
    output opcode,
    input  pc_inc, pc_out, mar_in, ram_out, ir_in, ir_out,
           acc_in, acc_out, b_in, sub, alu_out, out_in,
           t_state, halted
  );

endinterface

`default_nettype wire

// File: rtl/sap_ring_counter.sv
//------------------------------------------------------------------------------
// sap_ring_counter : 6-bit one-hot T-state rotator, falling-edge, hold input
// rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sap_ring_counter
  import sap_control_sequencer_pkg::*;
(
  input  wire logic               clock,
  input  wire logic               reset,
  input  wire logic               hold,
  output logic [T_WIDTH-1:0]      t_state
);

  logic [T_WIDTH-1:0] t_state_q;
  logic [T_WIDTH-1:0] t_state_d;

  // Recovery wins over hold so a frozen ring can never sit on a bad code.
  always_comb begin
    t_state_d = t_state_q;
    if (!ring_is_onehot(t_state_q)) begin
      t_state_d = T_RESET;
    end else if (!hold) begin
      t_state_d = {t_state_q[T_WIDTH-2:0], t_state_q[T_WIDTH-1]};
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      t_state_q <= T_RESET;
    end else begin
      t_state_q <= t_state_d;
    end
  end

  assign t_state = t_state_q;

endmodule

`default_nettype wire

// File: rtl/sap_control_sequencer.sv
//------------------------------------------------------------------------------
// sap_control_sequencer : SAP-1 fetch/execute control word generator
// rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sap_control_sequencer
  import sap_control_sequencer_pkg::*;
#(
  parameter logic [3:0] OP_LDA_P = OP_LDA,
  parameter logic [3:0] OP_ADD_P = OP_ADD,
  parameter logic [3:0] OP_SUB_P = OP_SUB,
  parameter logic [3:0] OP_OUT_P = OP_OUT,
  parameter logic [3:0] OP_HLT_P = OP_HLT
) (
  input  wire logic               clock,
  input  wire logic               reset,
  sap_control_sequencer_if.master bus
);

  logic [T_WIDTH-1:0] t_state;
  logic               halted_q;
  logic               halted_d;
  ctrl_word_t         cw;

  sap_ring_counter u_ring (
    .clock   (clock),
    .reset   (reset),
    .hold    (halted_q),
    .t_state (t_state)
  );

  // Halt latches on the same falling edge that moves T4 -> T5.
  always_comb begin
    halted_d = halted_q;
    if (t_state[T4] && (bus.opcode == OP_HLT_P)) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  always_comb begin
    cw = '0;
    if (!halted_q) begin
      if (t_state[T1]) begin
        cw[CW_PC_OUT] = 1'b1;
        cw[CW_MAR_IN] = 1'b1;
      end
      if (t_state[T2]) begin
        cw[CW_PC_INC] = 1'b1;
      end
      if (t_state[T3]) begin
        cw[CW_RAM_OUT] = 1'b1;
        cw[CW_IR_IN]   = 1'b1;
      end
      if (t_state[T4]) begin
        if ((bus.opcode == OP_LDA_P) || (bus.opcode == OP_ADD_P) ||
            (bus.opcode == OP_SUB_P)) begin
          cw[CW_IR_OUT] = 1'b1;
          cw[CW_MAR_IN] = 1'b1;
        end else if (bus.opcode == OP_OUT_P) begin
          cw[CW_ACC_OUT] = 1'b1;
        end
      end
      if (t_state[T5]) begin
        if (bus.opcode == OP_LDA_P) begin
          cw[CW_RAM_OUT] = 1'b1;
          cw[CW_ACC_IN]  = 1'b1;
        end else if ((bus.opcode == OP_ADD_P) || (bus.opcode == OP_SUB_P)) begin
          cw[CW_RAM_OUT] = 1'b1;
          cw[CW_B_IN]    = 1'b1;
          cw[CW_SUB]     = (bus.opcode == OP_SUB_P);
        end else if (bus.opcode == OP_OUT_P) begin
          // Accumulator drives a rising edge late, so out_in waits a state.
          cw[CW_ACC_OUT] = 1'b1;
          cw[CW_OUT_IN]  = 1'b1;
        end
      end
      if (t_state[T6]) begin
        if ((bus.opcode == OP_ADD_P) || (bus.opcode == OP_SUB_P)) begin
          cw[CW_ALU_OUT] = 1'b1;
          cw[CW_ACC_IN]  = 1'b1;
          cw[CW_SUB]     = (bus.opcode == OP_SUB_P);
        end
      end
    end
  end

  assign bus.pc_inc  = cw[CW_PC_INC];
  assign bus.pc_out  = cw[CW_PC_OUT];
  assign bus.mar_in  = cw[CW_MAR_IN];
  assign bus.ram_out = cw[CW_RAM_OUT];
  assign bus.ir_in   = cw[CW_IR_IN];
  assign bus.ir_out  = cw[CW_IR_OUT];
  assign bus.acc_in  = cw[CW_ACC_IN];
  assign bus.acc_out = cw[CW_ACC_OUT];
  assign bus.b_in    = cw[CW_B_IN];
  assign bus.sub     = cw[CW_SUB];
  assign bus.alu_out = cw[CW_ALU_OUT];
  assign bus.out_in  = cw[CW_OUT_IN];
  assign bus.t_state = t_state;
  assign bus.halted  = halted_q;

endmodule

`default_nettype wire

// File: doc/sap_control_sequencer.md
Name: sap_control_sequencer

Overview:
- Controller-sequencer for the SAP-1 datapath; drives the control word into the accumulator, B register, ALU, PC, MAR, RAM, IR and output register.
- Sits directly upstream of the accumulator: generates acc_in/acc_out and the ALU enables that move results into and out of it.
- Six-state ring counter (T1..T6) for fetch plus execute of LDA, ADD, SUB, OUT and HLT.
- Latches halt and freezes the machine until reset.

Parameters:
OP_LDA, 4'h0, opcode for load accumulator from memory
OP_ADD, 4'h1, opcode for acc <= acc + mem
OP_SUB, 4'h2, opcode for acc <= acc - mem
OP_OUT, 4'hE, opcode for out_reg <= acc
OP_HLT, 4'hF, opcode for halt

Ports:
clock    input   1  system clock; state advances on falling edge
reset    input   1  asynchronous, active-high
opcode   input   4  IR upper nibble, valid from T4
pc_inc   output  1  increment program counter
pc_out   output  1  PC drives bus
mar_in   output  1  MAR loads from bus
ram_out  output  1  RAM drives bus
ir_in    output  1  IR loads from bus
ir_out   output  1  IR operand nibble drives bus
acc_in   output  1  accumulator loads from bus
acc_out  output  1  accumulator requests bus drive
b_in     output  1  B register loads from bus
sub      output  1  ALU subtract select
alu_out  output  1  ALU drives bus
out_in   output  1  output register loads from bus
t_state  output  6  one-hot ring state, bit0 = T1
halted   output  1  halt latched

Behaviour:
- Reset is asynchronous and active-high. While reset is high: t_state = 6'b000001 (T1), halted = 0.
- The control word is combinational from t_state, opcode and halted. Other than that, every output is 0 on reset.
- The ring rotates T1->T2->...->T6->T1 on each falling clock edge when not halted. Datapath registers capture on rising edges, so each T-state's control word is stable for the whole high phase.
- After reset deasserts, the first rising edge executes the T1 actions.
- Fetch, for every opcode:
  - T1: pc_out, mar_in.
  - T2: pc_inc.
  - T3: ram_out, ir_in.
- LDA: T4 ir_out, mar_in; T5 ram_out, acc_in; T6 idle.
- ADD: T4 ir_out, mar_in; T5 ram_out, b_in; T6 alu_out, acc_in, sub = 0.
- SUB: same as ADD, but sub = 1 during T5 and T6 so the ALU result has settled.
- OUT: T4 acc_out; T5 acc_out, out_in; T6 idle.
  - Reason: the accumulator registers its bus drive one rising edge after acc_out is sampled. acc_out must therefore span two states, and out_in waits for the second.
- HLT: at the falling edge that ends T4, halted <= 1 and the ring holds at T5.
  - While halted: all controls are 0, t_state is frozen, and the opcode input is ignored.
  - Only reset clears halted.
- Unrecognised opcode: T4..T6 idle (NOP); the ring continues normally.
- Mutual exclusion: at most one bus driver (pc_out, ram_out, ir_out, acc_out, alu_out) may be high in any state, with one exception: acc_out lingers for the OUT sequence only.
- Reset mid-instruction (any T-state or halted) returns immediately to T1 with controls set to the fetch T1 pattern. No partial register updates are owed.
- opcode is sampled combinationally only in T4..T6. Opcode changes during T1..T3 must not affect outputs.
- t_state is always exactly one-hot. Illegal encodings recover to T1 on the next falling edge.

Decomposition:
- Shared include sap_defs.vh holds:
  - the opcode constants (the defaults above);
  - the T-state index constants T1..T6;
  - the control-word bit indices, so the datapath top and this block agree.
- One natural sub-module: sap_ring_counter.
  - Contents: 6-bit one-hot rotator with falling-edge update, async reset to T1, hold input driven by halted, illegal-state recovery.
  - The decode logic stays in sap_control_sequencer.

Test Plan:
- Reset then run with opcode = 4'h0: t_state goes 01,02,04,08,10,20,01 across falling edges. Required controls: T1 {pc_out, mar_in}; T2 {pc_inc}; T3 {ram_out, ir_in}; T4 {ir_out, mar_in}; T5 {ram_out, acc_in}; T6 none.
- opcode = 4'h2 (SUB): T5 asserts {ram_out, b_in, sub}; T6 asserts {alu_out, acc_in, sub}. ADD with 4'h1 gives identical T5/T6 but sub = 0.
- opcode = 4'hE (OUT): acc_out high in T4 and T5; out_in high only in T5; no other bus driver asserted in T4..T6.
- opcode = 4'hF (HLT): halted = 1 after T4's falling edge, and t_state stays 6'b010000 for 20 cycles with all controls 0. Asserting reset then gives t_state = 01 and halted = 0 without any clock edge.
- Assert reset asynchronously mid-T5 of ADD (between edges): outputs switch immediately to the T1 pattern; b_in and acc_in are never high on the next rising edge.
- Opcode 4'h7 (undefined): T4..T6 all controls 0; the next T1 fetch proceeds normally. Toggling opcode during T1..T3 produces no output change.
